// File: rtl/weight_bank_loader.sv
// weight_bank_loader
//   Loads a serial valid/ready stream of weight words into NUM parallel RAM
//   banks (word k -> bank k%NUM, address k/NUM), then serves a parallel read:
//   one address in, NUM words out one cycle later.
// Ports
//   clk, rst        rising-edge clock, async active-high reset
//   start           begin a new load (honoured in IDLE/DONE only)
//   in_valid/in_data/in_ready   weight stream handshake
//   busy            load in progress
//   load_done       all NUM*DEPTH words written
//   rd_addr         common read address
//   rd_data[i]      bank i contents at rd_addr, registered

// One bank: synchronous write, registered read-first port.
module weight_bank_loader_bank #(
    parameter int WIDTH = 16,
    parameter int ADDR  = 9,
    parameter int DEPTH = 512
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [ADDR-1:0]  wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [ADDR-1:0]  rd_addr,
    output logic [WIDTH-1:0] rd_data
);
    (* ram_style = "distributed" *) logic [WIDTH-1:0] mem [0:DEPTH-1];

    // RAM has no reset so it maps onto plain distributed memory.
    always_ff @(posedge clk) begin
        if (we)
            mem[wr_addr] <= wr_data;
    end

    // Non-blocking read of the same array gives old data on a same-cycle write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            rd_data <= '0;
        else
            rd_data <= mem[rd_addr];
    end
endmodule

module weight_bank_loader #(
    parameter int WIDTH = 16,
    parameter int ADDR  = 9,
    parameter int NUM   = 64,
    parameter int DEPTH = 512
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             busy,
    output logic             load_done,
    input  logic [ADDR-1:0]  rd_addr,
    output logic [WIDTH-1:0] rd_data [0:NUM-1]
);
    localparam int BW = (NUM > 1) ? $clog2(NUM) : 1;
    localparam logic [BW-1:0]   LAST_BANK = BW'(NUM - 1);
    localparam logic [ADDR-1:0] LAST_ADDR = ADDR'(DEPTH - 1);

    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;
    state_t state, state_nxt;

    logic [BW-1:0]   bank_cnt;
    logic [ADDR-1:0] addr_cnt;
    logic            xfer;
    logic            last;

    assign xfer = in_valid && in_ready;
    assign last = (bank_cnt == LAST_BANK) && (addr_cnt == LAST_ADDR);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start)        state_nxt = LOAD;
            LOAD:    if (xfer && last) state_nxt = DONE;
            DONE:    if (start)        state_nxt = LOAD;
            default:                   state_nxt = IDLE;
        endcase
    end

    // Outputs decoded from state only
    always_comb begin
        in_ready  = (state == LOAD);
        busy      = (state == LOAD);
        load_done = (state == DONE);
    end

    // Stream position: bank index is the fast-moving digit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bank_cnt <= '0;
            addr_cnt <= '0;
        end else if (state != LOAD) begin
            if (start) begin
                bank_cnt <= '0;
                addr_cnt <= '0;
            end
        end else if (xfer) begin
            if (bank_cnt == LAST_BANK) begin
                bank_cnt <= '0;
                addr_cnt <= addr_cnt + 1'b1;
            end else begin
                bank_cnt <= bank_cnt + 1'b1;
            end
        end
    end

    genvar i;
    generate
        for (i = 0; i < NUM; i++) begin : g_bank
            weight_bank_loader_bank #(
                .WIDTH (WIDTH),
                .ADDR  (ADDR),
                .DEPTH (DEPTH)
            ) u_bank (
                .clk     (clk),
                .rst     (rst),
                .we      (xfer && (bank_cnt == BW'(i))),
                .wr_addr (addr_cnt),
                .wr_data (in_data),
                .rd_addr (rd_addr),
                .rd_data (rd_data[i])
            );
        end
    endgenerate
endmodule
